path_delay_meter: RTL and testbench
===================================

PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of delay counter and result.
REQ-002 The block SHALL have parameter TIMEOUT, default 200: maximum cycles per phase; must be < 2**CNT_W.
REQ-003 The block SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  in  1: synchronous, active-high reset.
REQ-005 The block SHALL have port start  in  1: measurement request; honoured only when busy=0.
REQ-006 The block SHALL have port polarity  in  1: 1 = measure rising launch, 0 = falling launch; sampled with start.
REQ-007 The block SHALL have port invert  in  1: inversion parity of the path under test; sampled with start.
REQ-008 The block SHALL have port launch  out  1: registered drive into the gate path under test.
REQ-009 The block SHALL have port sense  in  1: asynchronous path output.
REQ-010 The block SHALL have port busy  out  1: high from the cycle after an accepted start until done.
REQ-011 The block SHALL have port done  out  1: one-cycle pulse; result valid.
REQ-012 The block SHALL have port delay  out  CNT_W: measured cycles; held until next done.
REQ-013 The block SHALL have port timeout  out  1: last measurement timed out; held until next done.

Function
REQ-014 sense SHALL pass through a 2-flop synchronizer (sense_s) before any use.
REQ-015 exp = polarity XOR invert, latched at start acceptance.
REQ-016 FSM states SHALL be IDLE, PRESET, MEASURE, DONE.
REQ-017 IDLE + start: the FSM SHALL go to PRESET; launch <= ~polarity; cnt <= 0; busy <= 1.
REQ-018 PRESET SHALL increment cnt every cycle; when sense_s == ~exp it goes to MEASURE, launch <= polarity, cnt <= 0.
REQ-019 MEASURE SHALL increment cnt every cycle; when sense_s == exp it goes to DONE, delay <= cnt+1, timeout <= 0.
REQ-020 When cnt reaches TIMEOUT in PRESET or MEASURE, the FSM SHALL go to DONE with delay <= TIMEOUT, timeout <= 1.
REQ-021 Match and timeout in the same cycle SHALL report the match.
REQ-022 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE; launch holds its value.
REQ-023 start while busy=1 or in DONE SHALL be ignored, with no queuing.
REQ-024 Direct loopback (sense=launch, invert=0) SHALL report delay=3 (2 synchronizer cycles + 1 detect); every extra register stage in the path adds 1.
REQ-025 cnt SHALL never wrap: it saturates at TIMEOUT.

Reset
REQ-026 rst SHALL force IDLE, launch=0, busy=0, done=0, delay=0, timeout=0, cnt=0, synchronizer flops=0.
REQ-027 rst mid-measurement SHALL abort it with no done pulse; rst has priority over start.

Configuration
REQ-028 With PATH_DELAY_METER_MINMAX_EN defined, the block SHALL add outputs min_delay and max_delay (CNT_W) and input clr_stats.
REQ-029 With the macro defined, non-timeout results SHALL update min/max at done; rst or clr_stats sets min=all-ones, max=0; clr_stats has priority over a same-cycle update.
REQ-030 Without PATH_DELAY_METER_MINMAX_EN, those ports and registers SHALL be absent and behaviour is otherwise identical.

Structure
REQ-031 Package path_delay_meter_pkg SHALL hold the state enum and default CNT_W/TIMEOUT constants.
REQ-032 Sub-module pdm_sync (2-flop synchronizer, reset to 0) SHALL be instantiated once for sense.

Verification
REQ-033 Loopback sense=launch, invert=0, polarity=1 -> done after PRESET; delay=3, timeout=0, launch=1.
REQ-034 Path = NOT1 plus one register (invert=1), polarity=0 -> delay=4, timeout=0.
REQ-035 sense tied 0, polarity=1, invert=0, TIMEOUT=200 -> delay=200, timeout=1, single done pulse.
REQ-036 start pulsed every cycle during a measurement -> exactly one done; no restart until IDLE.
REQ-037 rst asserted mid-MEASURE -> no done; all outputs 0 on the next cycle.
REQ-038 With the macro, results 3, 5, 4 -> min=3, max=5; clr_stats -> min=all-ones, max=0.

Source files
------------

// File: rtl/path_delay_meter_pkg.sv
// Shared types and default sizing for the path delay meter.
package path_delay_meter_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 200;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESET  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pdm_sync.sv
// Two-flop synchronizer for the asynchronous sense input; both flops reset to 0.
module pdm_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/path_delay_meter.sv
// Launches an edge into a gate path and counts cycles until the synchronized sense follows.
// Optional min/max statistics are built when PATH_DELAY_METER_MINMAX_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// PRESET  | launch driven to the opposite level, waiting for the path to settle there
// MEASURE | measured edge launched, counting until sense reaches the expected level
// DONE    | one-cycle result pulse, then back to IDLE
module path_delay_meter
  import path_delay_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             polarity,
  input  logic             invert,
  output logic             launch,
  input  logic             sense,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] delay,
  output logic             timeout
`ifdef PATH_DELAY_METER_MINMAX_EN
  ,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] min_delay,
  output logic [CNT_W-1:0] max_delay
`endif
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  state_e           state_q;
  logic             exp_q, pol_q, launch_q, busy_q, done_q, timeout_q;
  logic [CNT_W-1:0] cnt_q, delay_q;
  logic [CNT_W-1:0] cnt_d, meas_val;
  logic             sense_s, cnt_at_to, meas_hit;

  pdm_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sense),
    .q_o (sense_s)
  );

  // Counter saturates at TIMEOUT so it can never wrap.
  assign cnt_at_to = (cnt_q == TO_VAL);
  assign cnt_d     = cnt_at_to ? cnt_q : cnt_q + CNT_W'(1);
  assign meas_val  = cnt_q + CNT_W'(1);
  assign meas_hit  = (state_q == MEASURE) && (sense_s == exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      exp_q     <= 1'b0;
      pol_q     <= 1'b0;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      delay_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= PRESET;
            exp_q    <= polarity ^ invert;
            pol_q    <= polarity;
            launch_q <= ~polarity;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        PRESET: begin
          cnt_q <= cnt_d;
          if (sense_s == ~exp_q) begin
            state_q  <= MEASURE;
            launch_q <= pol_q;
            cnt_q    <= '0;
          end else if (cnt_at_to) begin
            state_q   <= DONE;
            delay_q   <= TO_VAL;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        MEASURE: begin
          cnt_q <= cnt_d;
          // A match wins over a same-cycle timeout.
          if (meas_hit) begin
            state_q   <= DONE;
            delay_q   <= meas_val;
            timeout_q <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end else if (cnt_at_to) begin
            state_q   <= DONE;
            delay_q   <= TO_VAL;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign launch  = launch_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign delay   = delay_q;
  assign timeout = timeout_q;

`ifdef PATH_DELAY_METER_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  // Statistics land on the same edge that raises done.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      min_q <= '1;
      max_q <= '0;
    end else if (meas_hit) begin
      if (meas_val < min_q) min_q <= meas_val;
      if (meas_val > max_q) max_q <= meas_val;
    end
  end

  assign min_delay = min_q;
  assign max_delay = max_q;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter with a configurable model of the path under test.
module tb_path_delay_meter;

  localparam int BOUND = 500;

  logic       clk = 1'b0;
  logic       rst, start, polarity, invert;
  logic       launch, sense, busy, done, timeout;
  logic [7:0] delay;
`ifdef PATH_DELAY_METER_MINMAX_EN
  logic       clr_stats;
  logic [7:0] min_delay, max_delay;
`endif

  logic [1:0] cur_stages = 2'd0;
  logic       cur_invp   = 1'b0;
  logic       cur_tie0   = 1'b0;
  logic [2:0] chain      = 3'b000;
  logic       tap;
  int         n_checks   = 0;
  int         n_err      = 0;
  int         done_cnt   = 0;

  always #5 clk = ~clk;

  path_delay_meter #(.CNT_W(8), .TIMEOUT(200)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .polarity (polarity),
    .invert   (invert),
    .launch   (launch),
    .sense    (sense),
    .busy     (busy),
    .done     (done),
    .delay    (delay),
    .timeout  (timeout)
`ifdef PATH_DELAY_METER_MINMAX_EN
    ,
    .clr_stats(clr_stats),
    .min_delay(min_delay),
    .max_delay(max_delay)
`endif
  );

  // Path model: 0..3 register stages, optional inversion, or tied low.
  always @(posedge clk) chain <= {chain[1:0], launch};
  always_comb begin
    case (cur_stages)
      2'd0:    tap = launch;
      2'd1:    tap = chain[0];
      2'd2:    tap = chain[1];
      default: tap = chain[2];
    endcase
  end
  assign sense = cur_tie0 ? 1'b0 : (tap ^ cur_invp);

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic       pol;
    logic       inv;
    logic [1:0] stages;
    logic       invp;
    logic       tie0;
    logic [7:0] exp_delay;
    logic       exp_to;
    logic       exp_launch;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_wait: got no done within %0d cycles expected done", nm, BOUND);
    end
  endtask

  task automatic measure(input vec_t v, input string nm);
    cur_stages = v.stages;
    cur_invp   = v.invp;
    cur_tie0   = v.tie0;
    repeat (6) @(negedge clk);
    done_cnt = 0;
    polarity = v.pol;
    invert   = v.inv;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, busy, 1);
    wait_done(nm);
    chk({nm, "_delay"}, delay, v.exp_delay);
    chk({nm, "_timeout"}, timeout, v.exp_to);
    chk({nm, "_launch"}, launch, v.exp_launch);
    chk({nm, "_busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({nm, "_done_low"}, done, 0);
    repeat (3) @(negedge clk);
    chk({nm, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    //           pol   inv   stg   invp  tie0  delay  to    launch
    vecs[0] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3,   1'b0, 1'b1}; // loopback
    vecs[1] = '{1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 8'd4,   1'b0, 1'b0}; // NOT + 1 reg
    vecs[2] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'd200, 1'b1, 1'b0}; // wrong parity: PRESET timeout
    vecs[3] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3,   1'b0, 1'b0}; // falling loopback
    vecs[4] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 8'd200, 1'b1, 1'b1}; // tied 0: MEASURE timeout
    vecs[5] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'd5,   1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'd6,   1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'd5,   1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; polarity = 1'b0; invert = 1'b0;
`ifdef PATH_DELAY_METER_MINMAX_EN
    clr_stats = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_launch", launch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_delay", delay, 0);
    chk("rst_timeout", timeout, 0);
`ifdef PATH_DELAY_METER_MINMAX_EN
    chk("rst_min", min_delay, 8'hFF);
    chk("rst_max", max_delay, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) measure(vecs[i], $sformatf("vec%0d", i));

    // start held high through a whole measurement, including the DONE cycle
    cur_stages = 2'd0; cur_invp = 1'b0; cur_tie0 = 1'b0;
    repeat (6) @(negedge clk);
    done_cnt = 0;
    polarity = 1'b1; invert = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("hold_busy", busy, 1);
    wait_done("hold");
    chk("hold_delay", delay, 3);
    chk("hold_busy_at_done", busy, 0);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_no_restart", busy, 0);
    chk("hold_done_count", done_cnt, 1);

    // reset in the middle of MEASURE, with start asserted alongside
    cur_tie0 = 1'b1;
    repeat (6) @(negedge clk);
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_launch", launch, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_delay", delay, 0);
    chk("abort_timeout", timeout, 0);
    rst = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_still_idle", busy, 0);
    chk("abort_done_count", done_cnt, 0);

    measure(vecs[0], "recover");

`ifdef PATH_DELAY_METER_MINMAX_EN
    @(negedge clk);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    measure('{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1}, "mm3");
    measure('{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1}, "mm5");
    measure('{1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1}, "mm4");
    chk("mm_min", min_delay, 3);
    chk("mm_max", max_delay, 5);
    measure(vecs[4], "mm_to");
    chk("mm_min_after_to", min_delay, 3);
    chk("mm_max_after_to", max_delay, 5);
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    chk("mm_clr_min", min_delay, 8'hFF);
    chk("mm_clr_max", max_delay, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
